// File: rtl/reg_queue.sv
// reg_queue: DEPTH-entry, WIDTH-bit register queue with a registered pop stage.
// Push with load, pop with enable; popped data appears on reg_out one edge later
// and holds until the next accepted pop.
// Optional sticky overflow flag (ovf/ovf_clr ports) built only when the macro
// REG_QUEUE_OVF_EN is defined; without it dropped pushes are silent.
module reg_queue #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     load,
  input  logic                     enable,
  output logic [WIDTH-1:0]         reg_out,
  output logic                     reg_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef REG_QUEUE_OVF_EN
  ,
  input  logic                     ovf_clr,
  output logic                     ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_reg_out;
  logic             r_reg_valid;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  // Status flags decode straight from the registered occupancy.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // push that is paired with a pop; the write lands in the slot just read.
  assign w_push = load && (!w_full || enable);
  assign w_pop  = enable && !w_empty;

  // Occupancy next-state: +1 push only, -1 pop only, otherwise unchanged.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Registered output stage: capture the head word on an accepted pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_out   <= '0;
      r_reg_valid <= 1'b0;
    end else begin
      r_reg_valid <= w_pop;
      if (w_pop) begin
        r_reg_out <= r_mem[r_rd_ptr];
      end
    end
  end

  assign reg_out   = r_reg_out;
  assign reg_valid = r_reg_valid;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;

`ifdef REG_QUEUE_OVF_EN
  logic r_ovf;

  // Sticky overflow: set on a dropped push, set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (load && w_full && !enable) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_reg_queue.sv
// tb_reg_queue: scoreboard bench for reg_queue (WIDTH=5, DEPTH=4).
// Expected pop data is queued when a pop is driven and compared when reg_valid
// reports it; occupancy/flags come from a queue-based reference model.
module tb_reg_queue;

  localparam int W  = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          load;
  logic          enable;
  logic [W-1:0]  reg_out;
  logic          reg_valid;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
`ifdef REG_QUEUE_OVF_EN
  logic          ovf_clr;
  logic          ovf;
`endif

  always #5 clk = ~clk;

  reg_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load      (load),
    .enable    (enable),
    .reg_out   (reg_out),
    .reg_valid (reg_valid),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef REG_QUEUE_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf       (ovf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;
  logic         m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic exp_valid);
    logic [W-1:0] e;
    check_eq("reg_valid", {31'd0, reg_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_out = e;
      end
    end
    check_eq("reg_out", {27'd0, reg_out}, {27'd0, last_out});
    check_eq("count", {29'd0, count}, model_q.size());
    check_eq("full", {31'd0, full}, {31'd0, model_q.size() == D});
    check_eq("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
`ifdef REG_QUEUE_OVF_EN
    check_eq("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
  endtask

  // One clock of stimulus: update the model, drive, then check after the edge.
  task automatic step(input logic ld, input logic en, input logic [W-1:0] din, input logic clr);
    logic do_pop;
    logic do_push;
    do_pop  = en && (model_q.size() > 0);
    do_push = ld && ((model_q.size() < D) || en);
    if (ld && (model_q.size() == D) && !en) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (do_pop) exp_q.push_back(model_q.pop_front());
    if (do_push) model_q.push_back(din);
    load    = ld;
    enable  = en;
    data_in = din;
`ifdef REG_QUEUE_OVF_EN
    ovf_clr = clr;
`endif
    @(posedge clk);
    #1;
    load   = 1'b0;
    enable = 1'b0;
`ifdef REG_QUEUE_OVF_EN
    ovf_clr = 1'b0;
`endif
    check_outputs(do_pop);
  endtask

  task automatic do_reset(input logic ld, input logic en);
    rst     = 1'b1;
    load    = ld;
    enable  = en;
    data_in = 5'h1B;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_out = '0;
    m_ovf    = 1'b0;
    check_outputs(1'b0);
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    load     = 1'b0;
    enable   = 1'b0;
    data_in  = '0;
`ifdef REG_QUEUE_OVF_EN
    ovf_clr  = 1'b0;
`endif
    last_out = '0;
    m_ovf    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then idle pops on an empty queue.
    do_reset(1'b0, 1'b0);
    repeat (5) pop();

    // Fill and drain.
    for (int unsigned k = 1; k <= 4; k++) push(W'(k));
    repeat (4) pop();
    pop();

    // Overflow: dropped push, then drain returns only the original words.
    for (int unsigned k = 1; k <= 4; k++) push(W'(k));
    push(5'h1F);
    step(1'b1, 1'b0, 5'h1E, 1'b1);   // set and clear together: set wins
    repeat (4) pop();
    step(1'b0, 1'b0, '0, 1'b0);      // ovf still sticky
    step(1'b0, 1'b0, '0, 1'b1);      // clear pulse

    // Full with push+pop together, then empty with push+pop together.
    for (int unsigned k = 1; k <= 4; k++) push(W'(k));
    step(1'b1, 1'b1, 5'h0A, 1'b0);
    repeat (4) pop();
    step(1'b1, 1'b1, 5'h11, 1'b0);
    pop();

    // Wrap-around with paired push/pop at occupancy 2.
    push(5'h00);
    push(5'h01);
    for (int unsigned k = 2; k <= 9; k++) step(1'b1, 1'b1, W'(k), 1'b0);
    repeat (2) pop();

    // Random traffic.
    for (int unsigned k = 0; k < 80; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           W'($urandom_range(0, 31)), 1'($urandom_range(0, 7) == 0));
    end

    // Reset mid-burst with load and enable asserted.
    do_reset(1'b0, 1'b0);
    for (int unsigned k = 0; k < 3; k++) push(W'(5'h05 + k));
    do_reset(1'b1, 1'b1);
    push(5'h15);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
